bitbakery_serial_rx_packet: RTL and testbench

Receive side of the BitBakery serial link: deserializes an 8E1 UART stream and reassembles the 13-byte game-state packet (0xFF header, D0, D1, D2, eight obstacle-map bytes, 0xFF trailer). It sits on the game-board end of the link, after the pad synchronizer boundary. It presents the three data bytes and the 64-bit obstacle map as registered outputs that change only when a complete, error-free packet has been received.

---
 rtl/bitbakery_serial_rx_packet.sv | 200 ++++++++++++++++++++
 tb/tb_bitbakery_serial_rx_packet.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbakery_serial_rx_packet.sv
// BitBakery link receiver: 8E1 UART deserializer feeding a 13-byte packet assembler.
// The byte and packet outputs are committed together, and only after the 0xFF trailer is checked.
module bitbakery_serial_rx_packet #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        entrada_serial,
   output logic [7:0]  D0,
   output logic [7:0]  D1,
   output logic [7:0]  D2,
   output logic [63:0] map_obstacles,
   output logic        pacote_valido,
   output logic        erro,
   output logic        ocupado,
   output logic [3:0]  db_estado
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int OW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_CLKS - 1);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      DATA   = 4'd2,
      PARITY = 4'd3,
      STOP   = 4'd4
   } byte_state_t;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } pkt_state_t;

   logic              r_sync1, r_sync2, r_prev;
   byte_state_t       r_bstate, w_bnext;
   logic [TW-1:0]     r_timer;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic              r_par;
   logic              w_line, w_fall, w_tick;
   logic              w_byte_ok, w_byte_err;

   pkt_state_t        r_pstate, w_pnext;
   logic [3:0]        r_idx;
   logic [OW-1:0]     r_to;
   logic [7:0]        r_sh_d0, r_sh_d1, r_sh_d2;
   logic [63:0]       r_sh_map;
   logic [7:0]        r_d0, r_d1, r_d2;
   logic [63:0]       r_map;
   logic              r_valid, r_err;
   logic              w_commit, w_err, w_store;

   // Sync flops and edge history idle high so reset never looks like a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= entrada_serial;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_line = r_sync2;
   assign w_fall = r_prev & ~r_sync2;
   // Timer reads n-1 at n cycles into a phase, so the start sample lands at t0 + H.
   assign w_tick = (r_bstate == START) ? (r_timer == HALF_LAST) : (r_timer == BIT_LAST);

   always_comb begin
      w_bnext    = r_bstate;
      w_byte_ok  = 1'b0;
      w_byte_err = 1'b0;
      case (r_bstate)
         IDLE:    if (w_fall) w_bnext = START;
         START:   if (w_tick) w_bnext = w_line ? IDLE : DATA;
         DATA:    if (w_tick && r_bitcnt == 3'd7) w_bnext = PARITY;
         PARITY:  if (w_tick) w_bnext = STOP;
         STOP: begin
            if (w_tick) begin
               w_bnext = IDLE;
               if (w_line && ((^{r_shift, r_par}) == 1'b0)) w_byte_ok = 1'b1;
               else w_byte_err = 1'b1;
            end
         end
         default: w_bnext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_bstate <= IDLE;
         r_timer  <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
      end else begin
         r_bstate <= w_bnext;
         if (r_bstate == IDLE || w_tick) r_timer <= '0;
         else r_timer <= r_timer + 1'b1;
         if (r_bstate == IDLE) r_bitcnt <= '0;
         else if (r_bstate == DATA && w_tick) begin
            r_shift  <= {w_line, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
         end
         if (r_bstate == PARITY && w_tick) r_par <= w_line;
      end
   end

   always_comb begin
      w_pnext  = r_pstate;
      w_commit = 1'b0;
      w_err    = 1'b0;
      w_store  = 1'b0;
      case (r_pstate)
         HUNT: begin
            if (w_byte_err) w_err = 1'b1;
            else if (w_byte_ok && r_shift == 8'hFF) w_pnext = RECV;
         end
         RECV: begin
            if (w_byte_err) begin
               w_err   = 1'b1;
               w_pnext = HUNT;
            end else if (w_byte_ok) begin
               if (r_idx == 4'd12) begin
                  if (r_shift == 8'hFF) w_commit = 1'b1;
                  else w_err = 1'b1;
                  w_pnext = HUNT;
               end else begin
                  w_store = 1'b1;
               end
            end else if (r_to == TO_LAST) begin
               w_err   = 1'b1;
               w_pnext = HUNT;
            end
         end
         default: w_pnext = HUNT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pstate <= HUNT;
         r_idx    <= '0;
         r_to     <= '0;
         r_sh_d0  <= '0;
         r_sh_d1  <= '0;
         r_sh_d2  <= '0;
         r_sh_map <= '0;
         r_d0     <= '0;
         r_d1     <= '0;
         r_d2     <= '0;
         r_map    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_pstate <= w_pnext;
         r_valid  <= w_commit;
         r_err    <= w_err;
         if (w_pnext == HUNT) r_idx <= '0;
         else if (r_pstate == HUNT) r_idx <= 4'd1;
         else if (w_store) r_idx <= r_idx + 1'b1;
         if (r_pstate != RECV || w_byte_ok || w_byte_err) r_to <= '0;
         else r_to <= r_to + 1'b1;
         if (w_store) begin
            case (r_idx)
               4'd1: r_sh_d0 <= r_shift;
               4'd2: r_sh_d1 <= r_shift;
               4'd3: r_sh_d2 <= r_shift;
               default: begin
                  for (int k = 0; k < 8; k++)
                     if (r_idx == 4'(k + 4)) r_sh_map[k*8 +: 8] <= r_shift;
               end
            endcase
         end
         if (w_commit) begin
            r_d0  <= r_sh_d0;
            r_d1  <= r_sh_d1;
            r_d2  <= r_sh_d2;
            r_map <= r_sh_map;
         end
      end
   end

   assign D0            = r_d0;
   assign D1            = r_d1;
   assign D2            = r_d2;
   assign map_obstacles = r_map;
   assign pacote_valido = r_valid;
   assign erro          = r_err;
   assign ocupado       = (r_pstate == RECV);
   assign db_estado     = r_bstate;

endmodule

// File: tb/tb_bitbakery_serial_rx_packet.sv
// Directed bench for bitbakery_serial_rx_packet: drives 8E1 frames at CLKS_PER_BIT = 8
// and checks committed packets, error pulses, timeout, glitch rejection and reset abort.
module tb_bitbakery_serial_rx_packet;

   localparam int C       = 8;
   localparam int TO      = 20 * C;
   // One 8E1 frame is start + 8 data + parity + stop = 11 bit times.
   localparam int PKT_CYC = 13 * 11 * C;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        line = 1'b1;
   logic [7:0]  D0, D1, D2;
   logic [63:0] map_obstacles;
   logic        pacote_valido, erro, ocupado;
   logic [3:0]  db_estado;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_err = 0;
   int v_last = 0;
   int v_prev = 0;
   int e_last = 0;
   logic [7:0]  d0_at_pulse;
   logic [63:0] map_at_pulse;
   logic [7:0]  pkt [13];

   bitbakery_serial_rx_packet #(.CLKS_PER_BIT(C), .TIMEOUT_CLKS(TO)) dut (
      .clock          (clk),
      .reset          (rst_n),
      .entrada_serial (line),
      .D0             (D0),
      .D1             (D1),
      .D2             (D2),
      .map_obstacles  (map_obstacles),
      .pacote_valido  (pacote_valido),
      .erro           (erro),
      .ocupado        (ocupado),
      .db_estado      (db_estado)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: records every commit/error pulse and checks their exclusivity.
   always @(negedge clk) begin
      if (rst_n && (pacote_valido || erro)) begin
         checks++;
         if (pacote_valido && erro) begin
            errors++;
            $display("FAIL pulse_exclusive: pacote_valido=%b erro=%b required not both", pacote_valido, erro);
         end
         checks++;
         if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL ocupado_at_pulse: got %b required 0", ocupado);
         end
         if (pacote_valido) begin
            n_valid++;
            v_prev = v_last;
            v_last = cyc;
            d0_at_pulse = D0;
            map_at_pulse = map_obstacles;
         end
         if (erro) begin
            n_err++;
            e_last = cyc;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      line = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         repeat (C) @(negedge clk);
      end
      line = (^b) ^ bad_par;
      repeat (C) @(negedge clk);
      line = 1'b1;
      repeat (C) @(negedge clk);
   endtask

   task automatic load_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [63:0] m, input logic [7:0] tr);
      pkt[0] = 8'hFF;
      pkt[1] = a;
      pkt[2] = b;
      pkt[3] = c;
      for (int k = 0; k < 8; k++) pkt[4+k] = m[k*8 +: 8];
      pkt[12] = tr;
   endtask

   task automatic send_packet(input int nbytes, input int bad_idx);
      for (int i = 0; i < nbytes; i++) send_byte(pkt[i], (i == bad_idx));
   endtask

   task automatic test_reset;
      line  = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (D0 !== 8'h00) begin errors++; $display("FAIL reset_d0: got %h required 00", D0); end
      checks++; if (D2 !== 8'h00) begin errors++; $display("FAIL reset_d2: got %h required 00", D2); end
      checks++; if (map_obstacles !== 64'h0) begin errors++; $display("FAIL reset_map: got %h required 0", map_obstacles); end
      checks++; if (pacote_valido !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", pacote_valido); end
      checks++; if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro: got %b required 0", erro); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado: got %b required 0", ocupado); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", db_estado); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_nominal;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'h12, 8'h34, 8'h56, 64'h0807060504030201, 8'hFF);
      send_packet(12, -1);
      checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL nominal_busy: got %b required 1", ocupado); end
      send_byte(pkt[12], 1'b0);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL nominal_valid_count: got %0d required 1", n_valid - v0); end
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL nominal_err_count: got %0d required 0", n_err - e0); end
      checks++; if (D0 !== 8'h12) begin errors++; $display("FAIL nominal_d0: got %h required 12", D0); end
      checks++; if (D1 !== 8'h34) begin errors++; $display("FAIL nominal_d1: got %h required 34", D1); end
      checks++; if (D2 !== 8'h56) begin errors++; $display("FAIL nominal_d2: got %h required 56", D2); end
      checks++; if (map_obstacles !== 64'h0807060504030201) begin errors++; $display("FAIL nominal_map: got %h required 0807060504030201", map_obstacles); end
      checks++; if (d0_at_pulse !== 8'h12) begin errors++; $display("FAIL nominal_d0_at_pulse: got %h required 12", d0_at_pulse); end
      checks++; if (map_at_pulse !== 64'h0807060504030201) begin errors++; $display("FAIL nominal_map_at_pulse: got %h required 0807060504030201", map_at_pulse); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL nominal_idle: got %b required 0", ocupado); end
   endtask

   task automatic test_parity_error;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'hA1, 8'hB2, 8'hC3, 64'h1122334455667788, 8'hFF);
      send_packet(6, 5);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL parity_err_count: got %0d required 1", n_err - e0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL parity_valid_count: got %0d required 0", n_valid - v0); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL parity_ocupado: got %b required 0", ocupado); end
      checks++; if (D0 !== 8'h12) begin errors++; $display("FAIL parity_d0_kept: got %h required 12", D0); end
      checks++; if (map_obstacles !== 64'h0807060504030201) begin errors++; $display("FAIL parity_map_kept: got %h required 0807060504030201", map_obstacles); end
      send_packet(13, -1);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL parity_recover_count: got %0d required 1", n_valid - v0); end
      checks++; if (D1 !== 8'hB2) begin errors++; $display("FAIL parity_recover_d1: got %h required B2", D1); end
      checks++; if (map_obstacles !== 64'h1122334455667788) begin errors++; $display("FAIL parity_recover_map: got %h required 1122334455667788", map_obstacles); end
   endtask

   task automatic test_bad_trailer;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'h5A, 8'h5B, 8'h5C, 64'hDEADBEEF00C0FFEE, 8'hFE);
      send_packet(13, -1);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL trailer_err_count: got %0d required 1", n_err - e0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL trailer_valid_count: got %0d required 0", n_valid - v0); end
      checks++; if (D0 !== 8'hA1) begin errors++; $display("FAIL trailer_d0_kept: got %h required A1", D0); end
   endtask

   task automatic test_ff_payload;
      int v0;
      v0 = n_valid;
      load_pkt(8'hFF, 8'h00, 8'h7E, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      send_packet(13, -1);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL ff_valid_count: got %0d required 1", n_valid - v0); end
      checks++; if (D0 !== 8'hFF) begin errors++; $display("FAIL ff_d0: got %h required FF", D0); end
      checks++; if (D2 !== 8'h7E) begin errors++; $display("FAIL ff_d2: got %h required 7E", D2); end
      checks++; if (map_obstacles !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL ff_map: got %h required all ones", map_obstacles); end
   endtask

   task automatic test_timeout_glitch;
      int v0, e0, t_start, dly;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'h01, 8'h02, 8'h03, 64'h0, 8'hFF);
      send_packet(4, -1);
      checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b required 1", ocupado); end
      t_start = cyc;
      for (int i = 0; i < 250 && n_err == e0; i++) @(negedge clk);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d required 1", n_err - e0); end
      dly = e_last - t_start;
      checks++; if (dly < TO - 10 || dly > TO + 10) begin errors++; $display("FAIL timeout_delay: got %0d cycles required about %0d", dly, TO); end
      @(negedge clk);
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL timeout_ocupado: got %b required 0", ocupado); end
      line = 1'b0;
      repeat (2) @(negedge clk);
      line = 1'b1;
      repeat (5 * C) @(negedge clk);
      checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL glitch_err_count: got %0d required 1", n_err - e0); end
      checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL glitch_valid_count: got %0d required 0", n_valid - v0); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL glitch_state: got %0d required 0", db_estado); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL glitch_ocupado: got %b required 0", ocupado); end
   endtask

   task automatic test_reset_mid_packet;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'h33, 8'h44, 8'h55, 64'hA5A5A5A55A5A5A5A, 8'hFF);
      send_packet(7, -1);
      line = 1'b0;
      repeat (C) @(negedge clk);
      line = 1'b1;
      repeat (3 * C) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (D0 !== 8'h00) begin errors++; $display("FAIL midreset_d0: got %h required 00", D0); end
      checks++; if (map_obstacles !== 64'h0) begin errors++; $display("FAIL midreset_map: got %h required 0", map_obstacles); end
      checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL midreset_ocupado: got %b required 0", ocupado); end
      checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d required 0", db_estado); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * C) @(negedge clk);
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL midreset_no_erro: got %0d required 0", n_err - e0); end
      send_packet(13, -1);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL midreset_valid_count: got %0d required 1", n_valid - v0); end
      checks++; if (D2 !== 8'h55) begin errors++; $display("FAIL midreset_d2: got %h required 55", D2); end
      checks++; if (map_obstacles !== 64'hA5A5A5A55A5A5A5A) begin errors++; $display("FAIL midreset_map_after: got %h required A5A5A5A55A5A5A5A", map_obstacles); end
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      v0 = n_valid; e0 = n_err;
      load_pkt(8'h10, 8'h20, 8'h30, 64'h0102030405060708, 8'hFF);
      send_packet(13, -1);
      load_pkt(8'hC0, 8'hC1, 8'hC2, 64'hF0E0D0C0B0A09080, 8'hFF);
      send_packet(13, -1);
      repeat (2 * C) @(negedge clk);
      checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d required 2", n_valid - v0); end
      checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL b2b_err_count: got %0d required 0", n_err - e0); end
      checks++; if (v_last - v_prev !== PKT_CYC) begin errors++; $display("FAIL b2b_spacing: got %0d cycles required %0d", v_last - v_prev, PKT_CYC); end
      checks++; if (D0 !== 8'hC0) begin errors++; $display("FAIL b2b_d0: got %h required C0", D0); end
      checks++; if (map_obstacles !== 64'hF0E0D0C0B0A09080) begin errors++; $display("FAIL b2b_map: got %h required F0E0D0C0B0A09080", map_obstacles); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_parity_error();
      test_bad_trailer();
      test_ff_payload();
      test_timeout_glitch();
      test_reset_mid_packet();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete within 2 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
